etc_pixel_writer: RTL

ETC_PIXEL_WRITER -- requirements
Module: etc_pixel_writer

---
 rtl/etc_pkg.sv | 25 ++
 rtl/etc_pix_addr_gen.sv | 33 +++
 rtl/etc_pixel_writer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/etc_pkg.sv
// Shared definitions for the ETC pixel writer.
//   IMG_W_LOG2 / BLK_LOG2 : image and block-grid geometry (128x128 px, 32x32 blocks)
//   PIX_TOTAL             : pixels in one frame
//   etc_state_e           : writer FSM states
//   *_LSB                 : RGBA8888 field offsets within a 32-bit pixel word
package etc_pkg;

    localparam int unsigned IMG_W_LOG2 = 7;
    localparam int unsigned BLK_LOG2   = 5;
    localparam int unsigned PIX_TOTAL  = 16384;
    localparam int unsigned CNT_W      = 15;

    localparam int unsigned R_LSB = 24;
    localparam int unsigned G_LSB = 16;
    localparam int unsigned B_LSB = 8;
    localparam int unsigned A_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2,
        DONE  = 2'd3
    } etc_state_e;

endpackage

// File: rtl/etc_pix_addr_gen.sv
// Combinational framebuffer address generator.
//   blockX/blockY : block column/row index
//   pixIdx        : pixel within the 4x4 block, column-major (x=[3:2], y=[1:0]);
//                   the out-of-block flag (bit 4) is screened by the caller
//   fb_addr       : ((blockY*4+y) << IMG_W_LOG2) + blockX*4 + x, truncated
//   in_range      : both block indices lie inside the block grid
module etc_pix_addr_gen
    import etc_pkg::*;
#(
    parameter int unsigned IMG_W_LOG2 = etc_pkg::IMG_W_LOG2,
    parameter int unsigned BLK_LOG2   = etc_pkg::BLK_LOG2
) (
    input  logic [7:0]              blockX,
    input  logic [7:0]              blockY,
    input  logic [3:0]              pixIdx,
    output logic [2*IMG_W_LOG2-1:0] fb_addr,
    output logic                    in_range
);

    localparam int unsigned AW = 2 * IMG_W_LOG2;

    logic [31:0] row_w;
    logic [31:0] col_w;

    always_comb begin
        row_w    = (32'(blockY) << 2) + 32'(pixIdx[1:0]);
        col_w    = (32'(blockX) << 2) + 32'(pixIdx[3:2]);
        fb_addr  = AW'((row_w << IMG_W_LOG2) + col_w);
        in_range = (32'(blockX) < (32'd1 << BLK_LOG2)) &&
                   (32'(blockY) < (32'd1 << BLK_LOG2));
    end

endmodule

// File: rtl/etc_pixel_writer.sv
// Writes decoded ETC pixels into a linear framebuffer, one pixel per 3 cycles.
//   sclk, rsrt          : clock, synchronous active-high reset
//   valid, blockX/Y,    : decoded pixel and its block/pixel coordinates
//   pixIdx, pixel_in
//   write_finish        : one-cycle acknowledge after the write cycle
//   fb_we/fb_addr/fb_din: framebuffer write port (one cycle per pixel)
//   frame_done          : sticky, every in-range pixel of the frame written
//   range_err           : sticky, an out-of-grid block pixel was dropped
module etc_pixel_writer
    import etc_pkg::*;
#(
    parameter int unsigned IMG_W_LOG2 = etc_pkg::IMG_W_LOG2,
    parameter int unsigned BLK_LOG2   = etc_pkg::BLK_LOG2
) (
    input  logic                    sclk,
    input  logic                    rsrt,
    input  logic                    valid,
    input  logic [7:0]              blockX,
    input  logic [7:0]              blockY,
    input  logic [4:0]              pixIdx,
    input  logic [31:0]             pixel_in,
    output logic                    write_finish,
    output logic                    fb_we,
    output logic [2*IMG_W_LOG2-1:0] fb_addr,
    output logic [31:0]             fb_din,
    output logic                    frame_done,
    output logic                    range_err
);

    localparam int unsigned AW = 2 * IMG_W_LOG2;

    etc_state_e        state_q, state_d;
    logic              write_finish_q, write_finish_d;
    logic              fb_we_q, fb_we_d;
    logic [AW-1:0]     fb_addr_q, fb_addr_d;
    logic [31:0]       fb_din_q, fb_din_d;
    logic              frame_done_q, frame_done_d;
    logic              range_err_q, range_err_d;
    logic              inrange_q, inrange_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;

    logic [AW-1:0]     addr_w;
    logic              in_range_w;

    etc_pix_addr_gen #(
        .IMG_W_LOG2 (IMG_W_LOG2),
        .BLK_LOG2   (BLK_LOG2)
    ) u_addr_gen (
        .blockX   (blockX),
        .blockY   (blockY),
        .pixIdx   (pixIdx[3:0]),
        .fb_addr  (addr_w),
        .in_range (in_range_w)
    );

    always_comb begin
        state_d        = state_q;
        write_finish_d = 1'b0;
        fb_we_d        = 1'b0;
        fb_addr_d      = fb_addr_q;
        fb_din_d       = fb_din_q;
        frame_done_d   = frame_done_q;
        range_err_d    = range_err_q;
        inrange_d      = inrange_q;
        pix_cnt_d      = pix_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (valid && !pixIdx[4] && !frame_done_q) begin
                    fb_addr_d = addr_w;
                    fb_din_d  = pixel_in;
                    inrange_d = in_range_w;
                    // fb_we is registered here so it is high exactly during WRITE
                    fb_we_d   = in_range_w;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                write_finish_d = 1'b1;
                if (!inrange_q) begin
                    range_err_d = 1'b1;
                end
                state_d = ACK;
            end
            ACK: begin
                if (inrange_q) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
                // counter MSB marks PIX_TOTAL reached
                if (pix_cnt_d[CNT_W-1]) begin
                    frame_done_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rsrt) begin
            state_q        <= IDLE;
            write_finish_q <= 1'b0;
            fb_we_q        <= 1'b0;
            fb_addr_q      <= '0;
            fb_din_q       <= '0;
            frame_done_q   <= 1'b0;
            range_err_q    <= 1'b0;
            inrange_q      <= 1'b0;
            pix_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            write_finish_q <= write_finish_d;
            fb_we_q        <= fb_we_d;
            fb_addr_q      <= fb_addr_d;
            fb_din_q       <= fb_din_d;
            frame_done_q   <= frame_done_d;
            range_err_q    <= range_err_d;
            inrange_q      <= inrange_d;
            pix_cnt_q      <= pix_cnt_d;
        end
    end

    assign write_finish = write_finish_q;
    assign fb_we        = fb_we_q;
    assign fb_addr      = fb_addr_q;
    assign fb_din       = fb_din_q;
    assign frame_done   = frame_done_q;
    assign range_err    = range_err_q;

endmodule
